// File: rtl/frac_dec_pkg.sv
// Shared types, widths and the reset-default coefficient set for the 2/3 fractional decimator.
package frac_dec_pkg;

    localparam int SAMPLE_WIDTH = 16;
    localparam int SAMPLE_FRAC  = 15;
    localparam int COEF_WIDTH   = 20;
    localparam int COEF_FRAC    = 18;
    localparam int DECIM_M      = 3;
    localparam int NUM_TAPS     = 72;
    localparam int L            = 2;
    localparam int PROD_WIDTH   = SAMPLE_WIDTH + COEF_WIDTH;
    localparam int ACC_WIDTH    = PROD_WIDTH + $clog2(NUM_TAPS / L);

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
    typedef logic signed [COEF_WIDTH-1:0]   coeff_t;
    typedef logic signed [PROD_WIDTH-1:0]   prod_t;
    typedef logic signed [ACC_WIDTH-1:0]    acc_t;
    typedef logic [NUM_TAPS-1:0][COEF_WIDTH-1:0] coeff_bank_t;

    // Triangular window: each polyphase branch sums to 666, and 666*393 is ~2^18, so each
    // branch has roughly unity gain and the prototype has the gain of 2 that L=2 needs.
    localparam int TRI_SCALE = 393;

    function automatic coeff_bank_t gen_default_coeff();
        coeff_bank_t bank;
        for (int n = 0; n < NUM_TAPS; n++) begin
            bank[n] = COEF_WIDTH'((n < NUM_TAPS / 2 ? n + 1 : NUM_TAPS - n) * TRI_SCALE);
        end
        return bank;
    endfunction

    localparam coeff_bank_t DEFAULT_COEFF = gen_default_coeff();

endpackage

// File: rtl/frac_dec_round_sat.sv
// Accumulator to Q1.15 conversion: round half-up, then clip with overflow/underflow flags.
module frac_dec_round_sat
    import frac_dec_pkg::*;
#(
    parameter int IN_FRAC  = SAMPLE_FRAC + COEF_FRAC,
    parameter int OUT_FRAC = SAMPLE_FRAC
) (
    input  acc_t    i_acc,
    output sample_t o_sample,
    output logic    o_ovf,
    output logic    o_unf
);

    localparam int   SHIFT   = IN_FRAC - OUT_FRAC;
    localparam acc_t SAT_MAX = acc_t'(2 ** (SAMPLE_WIDTH - 1) - 1);
    localparam acc_t SAT_MIN = acc_t'(-(2 ** (SAMPLE_WIDTH - 1)));

    function automatic acc_t round_half_up(input acc_t a);
        return (a + (acc_t'(1) <<< (SHIFT - 1))) >>> SHIFT;
    endfunction

    function automatic sample_t saturate(input acc_t a);
        if (a > SAT_MAX) begin
            return sample_t'(SAT_MAX);
        end else if (a < SAT_MIN) begin
            return sample_t'(SAT_MIN);
        end
        return sample_t'(a);
    endfunction

    acc_t w_rounded;

    always_comb begin
        w_rounded = round_half_up(i_acc);
        o_sample  = saturate(w_rounded);
        o_ovf     = (w_rounded > SAT_MAX);
        o_unf     = (w_rounded < SAT_MIN);
    end

endmodule

// File: rtl/fractional_decimator.sv
// 2/3 polyphase resampler: L=2 interpolation, prototype low-pass FIR, M=3 decimation.
module fractional_decimator
    import frac_dec_pkg::*;
#(
    parameter int DATA_WIDTH  = SAMPLE_WIDTH,
    parameter int DATA_FRAC   = SAMPLE_FRAC,
    parameter int COEFF_WIDTH = COEF_WIDTH,
    parameter int COEFF_FRAC  = COEF_FRAC,
    parameter int M           = DECIM_M,
    parameter int N_TAP       = NUM_TAPS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_in,
    input  logic                          coeff_wr_en,
    input  logic signed [COEFF_WIDTH-1:0] coeff_data_in [N_TAP],
    input  logic signed [DATA_WIDTH-1:0]  filter_in,
    output logic signed [DATA_WIDTH-1:0]  filter_out,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          valid_out
);

    localparam int NB = N_TAP / L;

    sample_t    r_x [NB];
    coeff_t     r_coeff [N_TAP];
    logic [1:0] r_phase;
    logic       r_vld_p0;
    logic       r_vld_p1;
    coeff_t     r_h_p0 [NB];
    prod_t      r_prod_p1 [NB];
    acc_t       w_acc;
    sample_t    w_sample;
    logic       w_ovf;
    logic       w_unf;
    logic       w_out_phase;

    assign w_out_phase = (r_phase < 2'(L));

    // Stage p0: delay line shift, phase advance, branch coefficient capture
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < NB; i++) r_x[i] <= '0;
            for (int i = 0; i < N_TAP; i++) r_coeff[i] <= coeff_t'(DEFAULT_COEFF[i]);
            r_phase  <= '0;
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p0 <= valid_in && w_out_phase;
            r_vld_p1 <= r_vld_p0;
            if (valid_in) begin
                r_x[0] <= filter_in;
                for (int i = 1; i < NB; i++) r_x[i] <= r_x[i-1];
                r_phase <= (r_phase == 2'(M - 1)) ? 2'd0 : r_phase + 2'd1;
            end
            if (coeff_wr_en) begin
                for (int i = 0; i < N_TAP; i++) r_coeff[i] <= coeff_data_in[i];
            end
        end
    end

    // Latching the branch here keeps a same-cycle coefficient write out of this sample
    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int k = 0; k < NB; k++) begin
                r_h_p0[k] <= (r_phase == 2'd1) ? r_coeff[2*k+1] : r_coeff[2*k];
            end
        end
    end

    // Stage p1: multiply
    always_ff @(posedge clk) begin
        if (r_vld_p0) begin
            for (int k = 0; k < NB; k++) begin
                r_prod_p1[k] <= prod_t'(r_x[k]) * prod_t'(r_h_p0[k]);
            end
        end
    end

    // Stage p2: sum, round, saturate, output register
    always_comb begin
        w_acc = '0;
        for (int k = 0; k < NB; k++) w_acc = w_acc + acc_t'(r_prod_p1[k]);
    end

    frac_dec_round_sat #(
        .IN_FRAC (DATA_FRAC + COEFF_FRAC),
        .OUT_FRAC(DATA_FRAC)
    ) u_round_sat (
        .i_acc   (w_acc),
        .o_sample(w_sample),
        .o_ovf   (w_ovf),
        .o_unf   (w_unf)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            filter_out <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            valid_out  <= 1'b0;
        end else begin
            valid_out <= r_vld_p1;
            if (r_vld_p1) begin
                filter_out <= w_sample;
                overflow   <= w_ovf;
                underflow  <= w_unf;
            end
        end
    end

endmodule

// File: tb/tb_fractional_decimator.sv
// Directed bench for fractional_decimator: reset, impulse timing, branches, clipping, coefficient update, rate.
module tb_fractional_decimator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               valid_in;
    logic               coeff_wr_en;
    logic signed [19:0] coeff_data_in [72];
    logic signed [15:0] filter_in;
    logic signed [15:0] filter_out;
    logic               overflow;
    logic               underflow;
    logic               valid_out;

    int total = 0;
    int bad   = 0;
    int cap_val [$];
    bit cap_ovf [$];
    bit cap_unf [$];
    int pulse_cnt = 0;

    fractional_decimator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .coeff_wr_en  (coeff_wr_en),
        .coeff_data_in(coeff_data_in),
        .filter_in    (filter_in),
        .filter_out   (filter_out),
        .overflow     (overflow),
        .underflow    (underflow),
        .valid_out    (valid_out)
    );

    always @(negedge clk) begin
        if (valid_out) begin
            cap_val.push_back(int'(filter_out));
            cap_ovf.push_back(overflow);
            cap_unf.push_back(underflow);
            pulse_cnt++;
        end
    end

    task automatic clear_cap();
        cap_val.delete();
        cap_ovf.delete();
        cap_unf.delete();
        pulse_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        valid_in = 1'b0;
        coeff_wr_en = 1'b0;
        filter_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        clear_cap();
    endtask

    task automatic zero_coeffs();
        for (int i = 0; i < 72; i++) coeff_data_in[i] = '0;
    endtask

    task automatic write_coeffs();
        coeff_wr_en = 1'b1;
        @(negedge clk);
        coeff_wr_en = 1'b0;
    endtask

    task automatic send(input int s);
        valid_in  = 1'b1;
        filter_in = 16'(s);
        @(negedge clk);
        valid_in  = 1'b0;
    endtask

    task automatic flush();
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        coeff_wr_en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            valid_in  = 1'b1;
            filter_in = 16'sd12345;
            @(negedge clk);
            total++;
            if ({filter_out, valid_out, overflow, underflow} !== 19'd0) begin
                bad++;
                $display("FAIL reset_hold cycle=%0d out=%0d vo=%0b ovf=%0b unf=%0b want all 0",
                         c, filter_out, valid_out, overflow, underflow);
            end
        end
        rst_n = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        clear_cap();
        send(16384);
        send(0);
        flush();
        total++;
        if (cap_val.size() != 2 || cap_val[0] != 25 || cap_val[1] != 98) begin
            bad++;
            $display("FAIL reset_first_phase got n=%0d v0=%0d v1=%0d want n=2 25 98", cap_val.size(),
                     cap_val.size() > 0 ? cap_val[0] : 0, cap_val.size() > 1 ? cap_val[1] : 0);
        end
    endtask

    task automatic test_impulse();
        int   stim [6] = '{16384, 0, 0, 0, 0, 0};
        int   ev [4]   = '{16384, 0, 0, 0};
        logic [7:0] vo;
        do_reset();
        zero_coeffs();
        coeff_data_in[0] = 20'sd262144;
        write_coeffs();
        vo = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                valid_in  = 1'b1;
                filter_in = 16'(stim[i]);
            end else begin
                valid_in = 1'b0;
            end
            @(negedge clk);
            vo[i] = valid_out;
        end
        valid_in = 1'b0;
        flush();
        total++;
        if (vo !== 8'h6C) begin
            bad++;
            $display("FAIL impulse_valid_pattern got=%b want=%b", vo, 8'h6C);
        end
        total++;
        if (cap_val.size() != 4) begin
            bad++;
            $display("FAIL impulse_count got=%0d want=4", cap_val.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= cap_val.size() || cap_val[i] != ev[i]) begin
                bad++;
                $display("FAIL impulse_out[%0d] got=%0d want=%0d", i,
                         i < cap_val.size() ? cap_val[i] : -99999, ev[i]);
            end
        end
    endtask

    task automatic test_odd_branch();
        do_reset();
        zero_coeffs();
        coeff_data_in[1] = 20'sd131072;
        write_coeffs();
        send(16384);
        send(16384);
        send(0);
        flush();
        total++;
        if (cap_val.size() != 2 || cap_val[0] != 0 || cap_val[1] != 8192) begin
            bad++;
            $display("FAIL odd_branch got n=%0d v0=%0d v1=%0d want n=2 0 8192", cap_val.size(),
                     cap_val.size() > 0 ? cap_val[0] : 0, cap_val.size() > 1 ? cap_val[1] : 0);
        end
    endtask

    task automatic test_saturation();
        int idx_a [4] = '{0, 1, 2, 26};
        int val_a [4] = '{32767, 0, 32767, 32767};
        bit ovf_a [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int idx_b [5] = '{0, 2, 26, 27, 52};
        int val_b [5] = '{-32768, -32768, -32768, 0, 0};
        bit unf_b [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int j;
        do_reset();
        zero_coeffs();
        for (int k = 0; k < 36; k++) coeff_data_in[2*k] = 20'sd262144;
        write_coeffs();
        for (int i = 0; i < 40; i++) send(32767);
        flush();
        total++;
        if (cap_val.size() != 27) begin
            bad++;
            $display("FAIL sat_pos_count got=%0d want=27", cap_val.size());
        end
        for (int i = 0; i < 4; i++) begin
            j = idx_a[i];
            total++;
            if (j >= cap_val.size() || cap_val[j] != val_a[i] || cap_ovf[j] != ovf_a[i] || cap_unf[j] != 1'b0) begin
                bad++;
                $display("FAIL sat_pos[%0d] got=%0d ovf=%0b unf=%0b want=%0d ovf=%0b unf=0", j,
                         j < cap_val.size() ? cap_val[j] : -99999,
                         j < cap_val.size() ? cap_ovf[j] : 1'b0,
                         j < cap_val.size() ? cap_unf[j] : 1'b0, val_a[i], ovf_a[i]);
            end
        end
        do_reset();
        write_coeffs();
        for (int i = 0; i < 40; i++) send(-32768);
        for (int i = 0; i < 39; i++) send(0);
        flush();
        total++;
        if (cap_val.size() != 53) begin
            bad++;
            $display("FAIL sat_neg_count got=%0d want=53", cap_val.size());
        end
        for (int i = 0; i < 5; i++) begin
            j = idx_b[i];
            total++;
            if (j >= cap_val.size() || cap_val[j] != val_b[i] || cap_unf[j] != unf_b[i] || cap_ovf[j] != 1'b0) begin
                bad++;
                $display("FAIL sat_neg[%0d] got=%0d unf=%0b ovf=%0b want=%0d unf=%0b ovf=0", j,
                         j < cap_val.size() ? cap_val[j] : -99999,
                         j < cap_val.size() ? cap_unf[j] : 1'b0,
                         j < cap_val.size() ? cap_ovf[j] : 1'b0, val_b[i], unf_b[i]);
            end
        end
    endtask

    task automatic test_coeff_update();
        int ev [3] = '{16384, 0, 8192};
        do_reset();
        zero_coeffs();
        coeff_data_in[0] = 20'sd262144;
        write_coeffs();
        coeff_data_in[0] = 20'sd131072;
        coeff_wr_en = 1'b1;
        valid_in    = 1'b1;
        filter_in   = 16'sd16384;
        @(negedge clk);
        coeff_wr_en = 1'b0;
        valid_in    = 1'b0;
        send(0);
        send(0);
        send(16384);
        flush();
        total++;
        if (cap_val.size() != 3) begin
            bad++;
            $display("FAIL coeff_upd_count got=%0d want=3", cap_val.size());
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= cap_val.size() || cap_val[i] != ev[i]) begin
                bad++;
                $display("FAIL coeff_upd_out[%0d] got=%0d want=%0d", i,
                         i < cap_val.size() ? cap_val[i] : -99999, ev[i]);
            end
        end
    endtask

    task automatic test_midstream_reset();
        for (int i = 0; i < 30; i++) send(20000);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            valid_in  = 1'b1;
            filter_in = 16'sd20000;
            @(negedge clk);
            total++;
            if ({filter_out, valid_out, overflow, underflow} !== 19'd0) begin
                bad++;
                $display("FAIL midreset_hold cycle=%0d out=%0d vo=%0b ovf=%0b unf=%0b want all 0",
                         c, filter_out, valid_out, overflow, underflow);
            end
        end
        rst_n = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        clear_cap();
        send(16384);
        send(0);
        flush();
        total++;
        if (cap_val.size() != 2 || cap_val[0] != 25 || cap_val[1] != 98) begin
            bad++;
            $display("FAIL midreset_restart got n=%0d v0=%0d v1=%0d want n=2 25 98", cap_val.size(),
                     cap_val.size() > 0 ? cap_val[0] : 0, cap_val.size() > 1 ? cap_val[1] : 0);
        end
    endtask

    function automatic int pat(input int i);
        return ((i * 12345 + 678) % 65536) - 32768;
    endfunction

    task automatic test_rate_gaps();
        int ref_val [$];
        int diffs;
        do_reset();
        for (int i = 0; i < 4800; i++) send(pat(i));
        flush();
        total++;
        if (pulse_cnt != 3200) begin
            bad++;
            $display("FAIL rate_continuous got=%0d want=3200", pulse_cnt);
        end
        ref_val = cap_val;
        do_reset();
        for (int i = 0; i < 4800; i++) begin
            send(pat(i));
            @(negedge clk);
        end
        flush();
        total++;
        if (pulse_cnt != 3200) begin
            bad++;
            $display("FAIL rate_gapped got=%0d want=3200", pulse_cnt);
        end
        diffs = 0;
        for (int i = 0; i < ref_val.size(); i++) begin
            if (i >= cap_val.size() || cap_val[i] != ref_val[i]) diffs++;
        end
        total++;
        if (diffs != 0 || ref_val.size() != cap_val.size()) begin
            bad++;
            $display("FAIL gap_sequence differing=%0d sizes=%0d/%0d want 0 differing", diffs,
                     cap_val.size(), ref_val.size());
        end
    endtask

    initial begin
        rst_n       = 1'b1;
        valid_in    = 1'b0;
        coeff_wr_en = 1'b0;
        filter_in   = '0;
        for (int i = 0; i < 72; i++) coeff_data_in[i] = '0;
        @(negedge clk);
        test_reset();
        test_impulse();
        test_odd_branch();
        test_saturation();
        test_coeff_update();
        test_midstream_reset();
        test_rate_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
